// File: rtl/tinyrv1_proc.sv
// ---------------------------------------------------------------------------
// tinyrv1_proc
// Five-stage (F, D, X, M, W) pipelined TinyRV1 core. Supports add, addi, mul,
// lw, sw, jal, jr, bne, csrr and csrw with full bypassing, a one-cycle
// load-use stall, jal resolved in D and bne/jr resolved in X.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-low reset
//   imemreq_*/imemresp_*  instruction fetch port (combinational response)
//   dmemreq_*/dmemresp_*  data port driven from M (combinational response)
//   in0..in2              system inputs readable as CSR 0xFC2..0xFC4
//   out0..out2            system outputs writable as CSR 0x7C2..0x7C4
//   trace_*               F-stage PC/instruction, W writeback value, D stall
// ---------------------------------------------------------------------------
module tinyrv1_proc (
    input  logic        clk,
    input  logic        rst,
    output logic        imemreq_val,
    output logic [31:0] imemreq_addr,
    input  logic [31:0] imemresp_data,
    output logic        dmemreq_val,
    output logic        dmemreq_type,
    output logic [31:0] dmemreq_addr,
    output logic [31:0] dmemreq_wdata,
    input  logic [31:0] dmemresp_rdata,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_inst,
    output logic [31:0] trace_data,
    output logic        trace_stall
);

    typedef enum logic [1:0] {SEL_SUM, SEL_MUL, SEL_CSR} resultSel_e;

    // Pipeline state
    logic [31:0] r_pcF, r_pcD, r_instD;
    logic        r_valD, r_valX, r_valM, r_valW;
    logic [4:0]  r_rdX, r_rdM, r_rdW;
    logic        r_wenX, r_wenM, r_wenW;
    resultSel_e  r_selX;
    logic        r_isLwX, r_isSwX, r_isBneX, r_isJrX, r_isCsrwX;
    logic        r_isLwM, r_isSwM, r_isCsrwM, r_isCsrwW;
    logic [1:0]  r_csrIdxX, r_csrIdxM, r_csrIdxW;
    logic [31:0] r_op1X, r_op2X, r_storeX, r_brTargetX;
    logic [31:0] r_resultM, r_storeM, r_resultW;
    logic [31:0] r_out0, r_out1, r_out2;
    logic [31:0] r_rf [0:31];

    // Decode fields of the D-stage instruction
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [11:0] w_csr;
    logic [31:0] w_immI, w_immS, w_immB, w_immJ;
    logic        w_isAluR, w_isAdd, w_isMul, w_isAddi, w_isLw, w_isSw;
    logic        w_isJal, w_isJr, w_isBne, w_isCsrr, w_isCsrw;
    logic        w_usesRs1, w_usesRs2, w_wenD, w_csrOk;
    logic [1:0]  w_csrIdxD;
    logic [31:0] w_rs1Val, w_rs2Val, w_op1D, w_op2D;
    resultSel_e  w_selD;
    logic [31:0] w_sum, w_prod, w_csrVal, w_resultX, w_resultM, w_targetX, w_pcNext;
    logic        w_takenX, w_jalD, w_stall;

    assign w_opcode = r_instD[6:0];
    assign w_rd     = r_instD[11:7];
    assign w_funct3 = r_instD[14:12];
    assign w_rs1    = r_instD[19:15];
    assign w_rs2    = r_instD[24:20];
    assign w_funct7 = r_instD[31:25];
    assign w_csr    = r_instD[31:20];
    assign w_immI   = {{20{r_instD[31]}}, r_instD[31:20]};
    assign w_immS   = {{20{r_instD[31]}}, r_instD[31:25], r_instD[11:7]};
    assign w_immB   = {{19{r_instD[31]}}, r_instD[31], r_instD[7], r_instD[30:25], r_instD[11:8], 1'b0};
    assign w_immJ   = {{11{r_instD[31]}}, r_instD[31], r_instD[19:12], r_instD[20], r_instD[30:21], 1'b0};

    assign w_isAluR = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000);
    assign w_isAdd  = w_isAluR && (w_funct7 == 7'b0000000);
    assign w_isMul  = w_isAluR && (w_funct7 == 7'b0000001);
    assign w_isAddi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
    assign w_isLw   = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010);
    assign w_isSw   = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010);
    assign w_isJal  = (w_opcode == 7'b1101111);
    assign w_isJr   = (w_opcode == 7'b1100111) && (w_funct3 == 3'b000);
    assign w_isBne  = (w_opcode == 7'b1100011) && (w_funct3 == 3'b001);
    assign w_isCsrr = (w_opcode == 7'b1110011) && (w_funct3 == 3'b010) && (w_csr[11:4] == 8'hFC) && w_csrOk;
    assign w_isCsrw = (w_opcode == 7'b1110011) && (w_funct3 == 3'b001) && (w_csr[11:4] == 8'h7C) && w_csrOk;

    assign w_usesRs1 = w_isAdd | w_isMul | w_isAddi | w_isLw | w_isSw | w_isJr | w_isBne | w_isCsrw;
    assign w_usesRs2 = w_isAdd | w_isMul | w_isSw | w_isBne;
    assign w_wenD    = (w_isAdd | w_isMul | w_isAddi | w_isLw | w_isJal | w_isCsrr) && (w_rd != 5'd0);

    // Only CSR numbers ending in 2, 3 or 4 map onto the three in/out ports
    always_comb begin
        w_csrOk   = 1'b1;
        w_csrIdxD = 2'd0;
        case (w_csr[3:0])
            4'h2:    w_csrIdxD = 2'd0;
            4'h3:    w_csrIdxD = 2'd1;
            4'h4:    w_csrIdxD = 2'd2;
            default: w_csrOk   = 1'b0;
        endcase
    end

    // Operand bypass: youngest producer wins (X, then M, then W, then the
    // register file). A load in X gives a bogus value here, but that case
    // always raises the stall so the value is never captured.
    always_comb begin
        w_rs1Val = r_rf[w_rs1];
        w_rs2Val = r_rf[w_rs2];
        if (r_valW && r_wenW && (r_rdW == w_rs1)) w_rs1Val = r_resultW;
        if (r_valM && r_wenM && (r_rdM == w_rs1)) w_rs1Val = w_resultM;
        if (r_valX && r_wenX && (r_rdX == w_rs1)) w_rs1Val = w_resultX;
        if (r_valW && r_wenW && (r_rdW == w_rs2)) w_rs2Val = r_resultW;
        if (r_valM && r_wenM && (r_rdM == w_rs2)) w_rs2Val = w_resultM;
        if (r_valX && r_wenX && (r_rdX == w_rs2)) w_rs2Val = w_resultX;
        if (w_rs1 == 5'd0) w_rs1Val = 32'd0;
        if (w_rs2 == 5'd0) w_rs2Val = 32'd0;
    end

    // Build the X operands. jal rides the adder as (PC+4)+0 to produce its
    // link value; csrw rides it as rs1+0 so the write value reaches W.
    always_comb begin
        w_op1D = w_isJal ? (r_pcD + 32'd4) : w_rs1Val;
        w_op2D = 32'd0;
        if (w_isAddi || w_isLw)                  w_op2D = w_immI;
        else if (w_isSw)                         w_op2D = w_immS;
        else if (w_isAdd || w_isMul || w_isBne)  w_op2D = w_rs2Val;
        w_selD = SEL_SUM;
        if (w_isMul)       w_selD = SEL_MUL;
        else if (w_isCsrr) w_selD = SEL_CSR;
    end

    // Execute stage: adder, low multiply product and the CSR input sample
    always_comb begin
        w_sum  = r_op1X + r_op2X;
        w_prod = r_op1X * r_op2X;
        case (r_csrIdxX)
            2'd0:    w_csrVal = in0;
            2'd1:    w_csrVal = in1;
            default: w_csrVal = in2;
        endcase
        case (r_selX)
            SEL_MUL: w_resultX = w_prod;
            SEL_CSR: w_resultX = w_csrVal;
            default: w_resultX = w_sum;
        endcase
        w_targetX = r_isJrX ? {r_op1X[31:1], 1'b0} : r_brTargetX;
    end

    assign w_resultM = r_isLwM ? dmemresp_rdata : r_resultM;
    assign w_takenX  = r_valX && ((r_isBneX && (r_op1X != r_op2X)) || r_isJrX);
    assign w_jalD    = r_valD && w_isJal && !w_takenX;
    assign w_stall   = r_valD && r_valX && r_isLwX && r_wenX && !w_takenX &&
                       ((w_usesRs1 && (w_rs1 == r_rdX)) || (w_usesRs2 && (w_rs2 == r_rdX)));

    // Next PC priority: X redirect beats the D-stage jal, which beats a stall
    always_comb begin
        w_pcNext = r_pcF + 32'd4;
        if (w_takenX)     w_pcNext = w_targetX;
        else if (w_jalD)  w_pcNext = r_pcD + w_immJ;
        else if (w_stall) w_pcNext = r_pcF;
    end

    // Control state: PC, stage valid bits and the output CSRs. Reset turns
    // every stage into a bubble so nothing in flight can commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pcF  <= 32'd0;
            r_valD <= 1'b0;
            r_valX <= 1'b0;
            r_valM <= 1'b0;
            r_valW <= 1'b0;
            r_out0 <= 32'd0;
            r_out1 <= 32'd0;
            r_out2 <= 32'd0;
        end else begin
            r_pcF <= w_pcNext;
            if (w_takenX || w_jalD) r_valD <= 1'b0;
            else if (!w_stall)      r_valD <= 1'b1;
            r_valX <= r_valD && !w_takenX && !w_stall;
            r_valM <= r_valX;
            r_valW <= r_valM;
            if (r_valW && r_isCsrwW) begin
                case (r_csrIdxW)
                    2'd0:    r_out0 <= r_resultW;
                    2'd1:    r_out1 <= r_resultW;
                    default: r_out2 <= r_resultW;
                endcase
            end
        end
    end

    // Datapath registers carry no reset; the valid bits above qualify them
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_pcD   <= r_pcF;
            r_instD <= imemresp_data;
        end
        r_rdX       <= w_rd;
        r_wenX      <= w_wenD;
        r_selX      <= w_selD;
        r_isLwX     <= w_isLw;
        r_isSwX     <= w_isSw;
        r_isBneX    <= w_isBne;
        r_isJrX     <= w_isJr;
        r_isCsrwX   <= w_isCsrw;
        r_csrIdxX   <= w_csrIdxD;
        r_op1X      <= w_op1D;
        r_op2X      <= w_op2D;
        r_storeX    <= w_rs2Val;
        r_brTargetX <= r_pcD + w_immB;
        r_rdM       <= r_rdX;
        r_wenM      <= r_wenX;
        r_isLwM     <= r_isLwX;
        r_isSwM     <= r_isSwX;
        r_isCsrwM   <= r_isCsrwX;
        r_csrIdxM   <= r_csrIdxX;
        r_resultM   <= w_resultX;
        r_storeM    <= r_storeX;
        r_rdW       <= r_rdM;
        r_wenW      <= r_wenM;
        r_isCsrwW   <= r_isCsrwM;
        r_csrIdxW   <= r_csrIdxM;
        r_resultW   <= w_resultM;
        if (rst && r_valW && r_wenW) r_rf[r_rdW] <= r_resultW;
    end

    assign imemreq_val   = rst;
    assign imemreq_addr  = r_pcF;
    assign dmemreq_val   = rst && r_valM && (r_isLwM || r_isSwM);
    assign dmemreq_type  = r_isSwM;
    assign dmemreq_addr  = r_resultM;
    assign dmemreq_wdata = r_storeM;
    assign out0          = r_out0;
    assign out1          = r_out1;
    assign out2          = r_out2;
    assign trace_addr    = r_pcF;
    assign trace_inst    = imemresp_data;
    assign trace_data    = r_resultW;
    assign trace_stall   = w_stall;

endmodule

// File: tb/tb_tinyrv1_proc.sv
// ---------------------------------------------------------------------------
// tb_tinyrv1_proc
// Directed testbench for tinyrv1_proc. Each scenario loads a tiny program,
// releases reset, records per-cycle trace/port values and compares them with
// hand-computed expectations. Cycle 0 is the first cycle after reset release.
// ---------------------------------------------------------------------------
module tb_tinyrv1_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr, imemresp_data;
    logic        dmemreq_val, dmemreq_type;
    logic [31:0] dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
    logic [31:0] in0, in1, in2, out0, out1, out2;
    logic [31:0] trace_addr, trace_inst, trace_data;
    logic        trace_stall;

    int passCount = 0;
    int checkCount = 0;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:255];

    logic [31:0] capData  [0:15];
    logic [31:0] capAddr  [0:15];
    logic [31:0] capDaddr [0:15];
    logic [31:0] capOut0  [0:15];
    logic [31:0] capOut2  [0:15];
    logic        capStall [0:15];
    logic        capDval  [0:15];
    logic        capDtype [0:15];

    // 10 ns clock
    always #5 clk = ~clk;

    tinyrv1_proc dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
        .in0(in0), .in1(in1), .in2(in2), .out0(out0), .out1(out1), .out2(out2),
        .trace_addr(trace_addr), .trace_inst(trace_inst), .trace_data(trace_data),
        .trace_stall(trace_stall)
    );

    // Combinational memories; stores land on the rising edge
    assign imemresp_data  = imem[imemreq_addr[7:2]];
    assign dmemresp_rdata = dmem[dmemreq_addr[9:2]];
    always @(posedge clk) begin
        if (dmemreq_val && dmemreq_type) dmem[dmemreq_addr[9:2]] <= dmemreq_wdata;
    end

    // Instruction encoders
    function automatic logic [31:0] encI(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] i, a, f, d, o;
        i = imm; a = rs1; f = f3; d = rd; o = op;
        return {i[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] encR(input int f7, input int rs2, input int rs1, input int rd);
        logic [31:0] s, b, a, d;
        s = f7; b = rs2; a = rs1; d = rd;
        return {s[6:0], b[4:0], a[4:0], 3'b000, d[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] encS(input int imm, input int rs2, input int rs1);
        logic [31:0] i, b, a;
        i = imm; b = rs2; a = rs1;
        return {i[11:5], b[4:0], a[4:0], 3'b010, i[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] encBne(input int imm, input int rs1, input int rs2);
        logic [31:0] i, b, a;
        i = imm; b = rs2; a = rs1;
        return {i[12], i[10:5], b[4:0], a[4:0], 3'b001, i[4:1], i[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] encJal(input int rd, input int imm);
        logic [31:0] i, d;
        i = imm; d = rd;
        return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] iAddi(input int rd, input int rs1, input int imm);
        return encI(imm, rs1, 0, rd, 'h13);
    endfunction
    function automatic logic [31:0] iAdd(input int rd, input int rs1, input int rs2);
        return encR(0, rs2, rs1, rd);
    endfunction
    function automatic logic [31:0] iMul(input int rd, input int rs1, input int rs2);
        return encR(1, rs2, rs1, rd);
    endfunction
    function automatic logic [31:0] iLw(input int rd, input int rs1, input int imm);
        return encI(imm, rs1, 2, rd, 'h03);
    endfunction
    function automatic logic [31:0] iJr(input int rs1);
        return encI(0, rs1, 0, 0, 'h67);
    endfunction
    function automatic logic [31:0] iCsrr(input int rd, input int csr);
        return encI(csr, 0, 2, rd, 'h73);
    endfunction
    function automatic logic [31:0] iCsrw(input int csr, input int rs1);
        return encI(csr, rs1, 1, 0, 'h73);
    endfunction

    // Fill instruction memory with nops before each program
    task automatic clearImem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h00000013;
    endtask

    // Hold reset for two edges, release it on a falling edge, land in cycle 0
    task automatic applyStimulus();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // Record n cycles of observable state, sampled 1 ns after each falling edge
    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            capData[c]  = trace_data;
            capAddr[c]  = trace_addr;
            capStall[c] = trace_stall;
            capDval[c]  = dmemreq_val;
            capDaddr[c] = dmemreq_addr;
            capDtype[c] = dmemreq_type;
            capOut0[c]  = out0;
            capOut2[c]  = out2;
            @(negedge clk);
            #1;
        end
    endtask

    // Reset values and the first fetches after release
    task automatic test_reset();
        clearImem();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (dmemreq_val !== 1'b0) $display("[TB] FAIL reset_dval got %b expected 0", dmemreq_val); else passCount++;
        checkCount++; if (out0 !== 32'd0) $display("[TB] FAIL reset_out0 got %h expected 0", out0); else passCount++;
        checkCount++; if (out1 !== 32'd0) $display("[TB] FAIL reset_out1 got %h expected 0", out1); else passCount++;
        checkCount++; if (out2 !== 32'd0) $display("[TB] FAIL reset_out2 got %h expected 0", out2); else passCount++;
        checkCount++; if (trace_stall !== 1'b0) $display("[TB] FAIL reset_stall got %b expected 0", trace_stall); else passCount++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkCount++; if (imemreq_addr !== 32'd0) $display("[TB] FAIL first_pc got %h expected 0", imemreq_addr); else passCount++;
        checkCount++; if (imemreq_val !== 1'b1) $display("[TB] FAIL first_ival got %b expected 1", imemreq_val); else passCount++;
        @(negedge clk); #1;
        checkCount++; if (imemreq_addr !== 32'd4) $display("[TB] FAIL second_pc got %h expected 4", imemreq_addr); else passCount++;
    endtask

    // Back-to-back dependent ALU ops through X/M bypass, plus multiply
    task automatic test_alu();
        int stalls;
        clearImem();
        imem[0] = iAddi(1, 0, 1); imem[1] = iAdd(2, 1, 1);
        applyStimulus(); runCycles(8);
        stalls = 0; for (int c = 0; c < 8; c++) if (capStall[c] === 1'b1) stalls++;
        checkCount++; if (capData[4] !== 32'd1) $display("[TB] FAIL addi_w got %h expected 1", capData[4]); else passCount++;
        checkCount++; if (capData[5] !== 32'd2) $display("[TB] FAIL add_w got %h expected 2", capData[5]); else passCount++;
        checkCount++; if (stalls !== 0) $display("[TB] FAIL alu_nostall got %0d expected 0", stalls); else passCount++;

        clearImem();
        imem[0] = iAddi(1, 0, 2); imem[1] = iAdd(2, 1, 1); imem[2] = iAdd(3, 2, 1);
        applyStimulus(); runCycles(8);
        stalls = 0; for (int c = 0; c < 8; c++) if (capStall[c] === 1'b1) stalls++;
        checkCount++; if (capData[4] !== 32'd2) $display("[TB] FAIL chain0 got %h expected 2", capData[4]); else passCount++;
        checkCount++; if (capData[5] !== 32'd4) $display("[TB] FAIL chain1 got %h expected 4", capData[5]); else passCount++;
        checkCount++; if (capData[6] !== 32'd6) $display("[TB] FAIL chain2 got %h expected 6", capData[6]); else passCount++;
        checkCount++; if (stalls !== 0) $display("[TB] FAIL chain_nostall got %0d expected 0", stalls); else passCount++;

        clearImem();
        imem[0] = iAddi(1, 0, 3); imem[1] = iMul(2, 1, 1); imem[2] = iAdd(3, 2, 2);
        applyStimulus(); runCycles(8);
        checkCount++; if (capData[4] !== 32'd3) $display("[TB] FAIL mul_src got %h expected 3", capData[4]); else passCount++;
        checkCount++; if (capData[5] !== 32'd9) $display("[TB] FAIL mul_w got %h expected 9", capData[5]); else passCount++;
        checkCount++; if (capData[6] !== 32'd18) $display("[TB] FAIL mul_use got %h expected 18", capData[6]); else passCount++;
    endtask

    // Load-use stall, M-stage load bypass, and a store of the result
    task automatic test_load_store();
        int stalls;
        clearImem();
        dmem[64] = 32'h0000cafe;
        dmem[65] = 32'd0;
        imem[0] = iAddi(1, 0, 'h100); imem[1] = iLw(2, 1, 0);
        imem[2] = iAdd(3, 2, 2);      imem[3] = encS(4, 3, 1);
        applyStimulus(); runCycles(12);
        stalls = 0; for (int c = 0; c < 12; c++) if (capStall[c] === 1'b1) stalls++;
        checkCount++; if (capData[4] !== 32'h100) $display("[TB] FAIL lw_base got %h expected 100", capData[4]); else passCount++;
        checkCount++; if (capData[5] !== 32'hcafe) $display("[TB] FAIL lw_w got %h expected cafe", capData[5]); else passCount++;
        checkCount++; if (capData[7] !== 32'h195fc) $display("[TB] FAIL lw_use got %h expected 195fc", capData[7]); else passCount++;
        checkCount++; if (capStall[3] !== 1'b1) $display("[TB] FAIL stall_cycle got %b expected 1", capStall[3]); else passCount++;
        checkCount++; if (stalls !== 1) $display("[TB] FAIL stall_count got %0d expected 1", stalls); else passCount++;
        checkCount++; if (capDval[4] !== 1'b1 || capDtype[4] !== 1'b0 || capDaddr[4] !== 32'h100)
            $display("[TB] FAIL lw_req got val=%b type=%b addr=%h expected 1 0 100", capDval[4], capDtype[4], capDaddr[4]); else passCount++;
        checkCount++; if (capDval[3] !== 1'b0) $display("[TB] FAIL no_req_nonmem got %b expected 0", capDval[3]); else passCount++;
        checkCount++; if (dmem[65] !== 32'h195fc) $display("[TB] FAIL sw_mem got %h expected 195fc", dmem[65]); else passCount++;
    endtask

    // jal squashes one slot; squashed csrw must not touch the outputs
    task automatic test_jal();
        clearImem();
        imem[0] = encJal(1, 'hc); imem[1] = iCsrw('h7C3, 1);
        imem[2] = iCsrw('h7C4, 1); imem[3] = iAdd(2, 1, 1);
        applyStimulus(); runCycles(10);
        checkCount++; if (capData[4] !== 32'd4) $display("[TB] FAIL jal_link got %h expected 4", capData[4]); else passCount++;
        checkCount++; if (capAddr[2] !== 32'hc) $display("[TB] FAIL jal_target got %h expected c", capAddr[2]); else passCount++;
        checkCount++; if (capData[6] !== 32'd8) $display("[TB] FAIL jal_use got %h expected 8", capData[6]); else passCount++;
        checkCount++; if (out1 !== 32'd0 || out2 !== 32'd0) $display("[TB] FAIL jal_squash got %h %h expected 0 0", out1, out2); else passCount++;
    endtask

    // Taken bne, not-taken bne and jr redirect from X
    task automatic test_branch();
        clearImem();
        imem[0] = iAddi(1, 0, 1); imem[1] = encBne(12, 1, 0);
        imem[2] = iCsrw('h7C3, 1); imem[3] = iCsrw('h7C4, 1); imem[4] = iAddi(2, 0, 7);
        applyStimulus(); runCycles(12);
        checkCount++; if (capAddr[3] !== 32'hc) $display("[TB] FAIL bne_pre got %h expected c", capAddr[3]); else passCount++;
        checkCount++; if (capAddr[4] !== 32'h10) $display("[TB] FAIL bne_target got %h expected 10", capAddr[4]); else passCount++;
        checkCount++; if (capData[8] !== 32'd7) $display("[TB] FAIL bne_after got %h expected 7", capData[8]); else passCount++;
        checkCount++; if (out1 !== 32'd0 || out2 !== 32'd0) $display("[TB] FAIL bne_squash got %h %h expected 0 0", out1, out2); else passCount++;

        clearImem();
        imem[0] = encBne(8, 0, 0); imem[1] = iAddi(1, 0, 4); imem[2] = iAddi(2, 0, 8);
        applyStimulus(); runCycles(8);
        checkCount++; if (capAddr[2] !== 32'h8) $display("[TB] FAIL bnt_pc got %h expected 8", capAddr[2]); else passCount++;
        checkCount++; if (capData[5] !== 32'd4) $display("[TB] FAIL bnt_w1 got %h expected 4", capData[5]); else passCount++;
        checkCount++; if (capData[6] !== 32'd8) $display("[TB] FAIL bnt_w2 got %h expected 8", capData[6]); else passCount++;

        clearImem();
        imem[0] = iAddi(5, 0, 'h14); imem[1] = iJr(5); imem[2] = iCsrw('h7C3, 5);
        imem[3] = iCsrw('h7C4, 5); imem[4] = iCsrw('h7C2, 5); imem[5] = iAddi(6, 0, 3);
        applyStimulus(); runCycles(12);
        checkCount++; if (capAddr[4] !== 32'h14) $display("[TB] FAIL jr_target got %h expected 14", capAddr[4]); else passCount++;
        checkCount++; if (capData[8] !== 32'd3) $display("[TB] FAIL jr_after got %h expected 3", capData[8]); else passCount++;
        checkCount++; if (out0 !== 32'd0 || out1 !== 32'd0 || out2 !== 32'd0)
            $display("[TB] FAIL jr_squash got %h %h %h expected 0 0 0", out0, out1, out2); else passCount++;
    endtask

    // csrr samples inN in X; csrw lands on outN the cycle after W
    task automatic test_csr();
        in0 = 32'd5; in1 = 32'h77;
        clearImem();
        imem[0] = iCsrr(1, 'hFC2); imem[1] = iCsrw('h7C2, 1);
        imem[2] = iCsrr(2, 'hFC3); imem[3] = iCsrw('h7C4, 2);
        applyStimulus(); runCycles(10);
        checkCount++; if (capData[4] !== 32'd5) $display("[TB] FAIL csrr_w got %h expected 5", capData[4]); else passCount++;
        checkCount++; if (capOut0[5] !== 32'd0) $display("[TB] FAIL out0_early got %h expected 0", capOut0[5]); else passCount++;
        checkCount++; if (capOut0[6] !== 32'd5) $display("[TB] FAIL out0_set got %h expected 5", capOut0[6]); else passCount++;
        checkCount++; if (capOut2[8] !== 32'h77) $display("[TB] FAIL out2_set got %h expected 77", capOut2[8]); else passCount++;
    endtask

    // Reset in the middle of a program throws away the in-flight csrw
    task automatic test_mid_reset();
        clearImem();
        imem[0] = iAddi(1, 0, 9); imem[1] = iCsrw('h7C3, 1);
        applyStimulus(); runCycles(4);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (out1 !== 32'd0) $display("[TB] FAIL midrst_out1 got %h expected 0", out1); else passCount++;
        checkCount++; if (out0 !== 32'd0) $display("[TB] FAIL midrst_out0 got %h expected 0", out0); else passCount++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkCount++; if (trace_addr !== 32'd0) $display("[TB] FAIL midrst_pc got %h expected 0", trace_addr); else passCount++;
        runCycles(8);
        checkCount++; if (out1 !== 32'd9) $display("[TB] FAIL rerun_out1 got %h expected 9", out1); else passCount++;
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b0; in0 = 32'd0; in1 = 32'd0; in2 = 32'd0;
        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
        test_reset();
        test_alu();
        test_load_store();
        test_jal();
        test_branch();
        test_csr();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
